// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. It grants one completed result per cycle and registers it onto the CDB.
// Grant order is starved requesters, then the priority class, then all requesters, each round-robin from ptr.

module cdb_wait_cnt #(
  parameter int CNT_W = 2,
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic req,
  input  logic gnt,
  output logic starved
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign starved = req && (cnt_q == CNT_W'(LIMIT));

  always_comb begin
    cnt_d = '0;
    if (!flush && req && !gnt)
      cnt_d = (cnt_q == CNT_W'(LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

module cdb_arbiter #(
  parameter int                   NUM_UNITS    = 4,
  parameter int                   TAG_W        = 4,
  parameter int                   DATA_W       = 32,
  parameter int                   ADDR_W       = 32,
  parameter logic [NUM_UNITS-1:0] PRIO_MASK    = '0,
  parameter int                   STARVE_LIMIT = 3,
  localparam int                  SRC_W        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int                  CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_UNITS-1:0]          req,
  input  logic [NUM_UNITS*TAG_W-1:0]    req_tag,
  input  logic [NUM_UNITS*DATA_W-1:0]   req_val,
  input  logic [NUM_UNITS*ADDR_W-1:0]   req_target,
  output logic [NUM_UNITS-1:0]          grant,
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]             cdb_val,
  output logic [ADDR_W-1:0]             cdb_target,
  output logic [SRC_W-1:0]              cdb_src
);
  logic [NUM_UNITS-1:0] starved, sel_set;
  logic [SRC_W-1:0]     ptr_q, ptr_d, gnt_idx;
  logic                 gnt_found;

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
  logic [ADDR_W-1:0] cdb_target_q, cdb_target_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    cdb_wait_cnt #(.CNT_W(CNT_W), .LIMIT(STARVE_LIMIT)) u_wait (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .req     (req[i]),
      .gnt     (grant[i]),
      .starved (starved[i])
    );
  end

  // First non-empty class wins; reset and flush suppress every class.
  always_comb begin
    sel_set = '0;
    if (!rst && !flush) begin
      if (|starved)                sel_set = starved;
      else if (|(req & PRIO_MASK)) sel_set = req & PRIO_MASK;
      else                         sel_set = req;
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    grant     = '0;
    for (int off = 0; off < NUM_UNITS; off++) begin
      idx = (int'(ptr_q) + off) % NUM_UNITS;
      if (!gnt_found && sel_set[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(idx);
      end
    end
    if (gnt_found) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found)
      ptr_d = (gnt_idx == SRC_W'(NUM_UNITS - 1)) ? '0 : gnt_idx + SRC_W'(1);
  end

  // Data fields hold when idle; only cdb_valid tells consumers a broadcast is live.
  always_comb begin
    cdb_valid_d  = gnt_found;
    cdb_tag_d    = cdb_tag_q;
    cdb_val_d    = cdb_val_q;
    cdb_target_d = cdb_target_q;
    cdb_src_d    = cdb_src_q;
    if (gnt_found) begin
      cdb_tag_d    = req_tag[gnt_idx*TAG_W +: TAG_W];
      cdb_val_d    = req_val[gnt_idx*DATA_W +: DATA_W];
      cdb_target_d = req_target[gnt_idx*ADDR_W +: ADDR_W];
      cdb_src_d    = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_val_q    <= '0;
      cdb_target_q <= '0;
      cdb_src_q    <= '0;
    end else begin
      ptr_q        <= ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_val_q    <= cdb_val_d;
      cdb_target_q <= cdb_target_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_val    = cdb_val_q;
  assign cdb_target = cdb_target_q;
  assign cdb_src    = cdb_src_q;
endmodule
